// File: rtl/cube_pkg.sv
// Shared definitions for the cube-root block.
//   state_t    : FSM state encoding (IDLE, CALC, DONE)
//   root_width : number of root bits needed for a given operand width
package cube_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // ceil(width / 3): the cube root of a width-bit value fits in this many bits
    function automatic int root_width(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/cube_root_trial.sv
// Combinational cube of a candidate root.
// The full 3*RW-bit product is kept, so the result is never truncated.
//   trial : RW-bit candidate root
//   cube  : 3*RW-bit value of trial^3
module cube_root_trial #(
    parameter int RW = 11
) (
    input  logic [RW-1:0]   trial,
    output logic [3*RW-1:0] cube
);

    logic [3*RW-1:0] trial_ext;

    assign trial_ext = {{(2 * RW){1'b0}}, trial};
    assign cube      = trial_ext * trial_ext * trial_ext;

endmodule

// File: rtl/cube_root.sv
// Iterative integer cube root, one root bit per cycle, MSB first.
// Ports:
//   clock, reset_n       : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake, num is the unsigned radicand
//   out_valid / out_ready: result handshake
//   root                 : floor(cbrt(num)), held until the next result completes
//   rem                  : num - root^3 (only when CUBE_ROOT_REM_EN is defined)
// Optional feature macro: CUBE_ROOT_REM_EN adds the rem output and its logic.
module cube_root
    import cube_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int RW = root_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CUBE_ROOT_REM_EN
    output logic [WIDTH-1:0] rem,
`endif
    output logic [RW-1:0]    root
);

    localparam int CW = 3 * RW;
    localparam int IW = (RW > 1) ? $clog2(RW) : 1;

    state_t           state_q;
    logic [WIDTH-1:0] num_q;
    logic [RW-1:0]    acc_q;
    logic [RW-1:0]    root_q;
    logic [IW-1:0]    idx_q;

    logic [RW-1:0]    trial;
    logic [CW-1:0]    trial_cube;
    logic [CW-1:0]    num_ext;
    logic             keep;
    logic [RW-1:0]    acc_next;

    // CW >= WIDTH always, so the compare is done at full cube width
    assign trial    = acc_q | (RW'(1) << idx_q);
    assign num_ext  = CW'(num_q);
    assign keep     = (trial_cube <= num_ext);
    assign acc_next = keep ? trial : acc_q;

    cube_root_trial #(
        .RW(RW)
    ) u_trial (
        .trial(trial),
        .cube (trial_cube)
    );

`ifdef CUBE_ROOT_REM_EN
    // Cube of the accepted bits so far, so rem needs no second multiplier
    logic [CW-1:0]    acc_cube_q;
    logic [CW-1:0]    cube_next;
    logic [WIDTH-1:0] rem_q;

    assign cube_next = keep ? trial_cube : acc_cube_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_cube_q <= '0;
            rem_q      <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                acc_cube_q <= '0;
            end else if (state_q == CALC) begin
                acc_cube_q <= cube_next;
                if (idx_q == '0) begin
                    rem_q <= WIDTH'(num_ext - cube_next);
                end
            end
        end
    end

    assign rem = rem_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            acc_q   <= '0;
            root_q  <= '0;
            idx_q   <= IW'(RW - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        num_q   <= num;
                        acc_q   <= '0;
                        idx_q   <= IW'(RW - 1);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_next;
                    if (idx_q == '0) begin
                        root_q  <= acc_next;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign root      = root_q;

endmodule

// File: tb/tb_cube_root.sv
module tb_cube_root;

    localparam int WIDTH = 32;
    localparam int RW    = 11;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    root;
`ifdef CUBE_ROOT_REM_EN
    logic [WIDTH-1:0] rem;
`endif

    int checks;
    int failures;
    logic [RW-1:0] last_root;
    logic [WIDTH-1:0] last_rem;

    cube_root #(
        .WIDTH(WIDTH)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .num      (num),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef CUBE_ROOT_REM_EN
        .rem      (rem),
`endif
        .root     (root)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: floating-point estimate, corrected with exact integer cubes
    function automatic longint unsigned ref_root(input longint unsigned n);
        longint unsigned r;
        r = longint'($floor($pow(real'(n), 1.0 / 3.0)));
        while (r > 0 && r * r * r > n) r = r - 1;
        while ((r + 1) * (r + 1) * (r + 1) <= n) r = r + 1;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] cur_rem();
`ifdef CUBE_ROOT_REM_EN
        return rem;
`else
        return '0;
`endif
    endfunction

    // Drives one operand and collects observations; callers do the comparisons.
    task automatic run_op(input logic [WIDTH-1:0] n, input int hold,
                          output logic [RW-1:0] r, output logic [WIDTH-1:0] rm,
                          output int lat, output int bad_ready, output int bad_hold,
                          output logic idle_ok);
        int wait_cnt;
        bad_ready = 0;
        bad_hold  = 0;
        wait_cnt  = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clock);
            wait_cnt++;
        end
        in_valid = 1'b1;
        num      = n;
        @(negedge clock);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) bad_ready++;
            if (root !== last_root || cur_rem() !== last_rem) bad_hold++;
            // Inputs must be ignored while busy
            in_valid = 1'($urandom);
            num      = $urandom;
            @(negedge clock);
            lat++;
        end
        r  = root;
        rm = cur_rem();
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            num       = $urandom;
            @(negedge clock);
            if (root !== r || cur_rem() !== rm || !out_valid) bad_hold++;
            if (in_ready) bad_ready++;
        end
        out_ready = 1'b1;
        @(negedge clock);
        idle_ok   = in_ready && !out_valid;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        last_root = r;
        last_rem  = rm;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num       = '0;
        last_root = '0;
        last_rem  = '0;
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake got in_ready=%b out_valid=%b exp 1 0",
                     in_ready, out_valid);
        end
        checks++;
        if (root !== '0 || cur_rem() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got root=%0d rem=%0d exp 0 0", root, cur_rem());
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] vals [6];
        logic [RW-1:0]    exp_r [6];
        logic [WIDTH-1:0] exp_m [6];
        logic [RW-1:0]    r;
        logic [WIDTH-1:0] rm;
        int lat, br, bh;
        logic idle_ok;
        vals = '{32'd0, 32'd27, 32'd28, 32'd26, 32'hFFFF_FFFF, 32'd4291015625};
        exp_r = '{11'd0, 11'd3, 11'd3, 11'd2, 11'd1625, 11'd1625};
        exp_m = '{32'd0, 32'd0, 32'd1, 32'd18, 32'd3951670, 32'd0};
        for (int i = 0; i < 6; i++) begin
            run_op(vals[i], 0, r, rm, lat, br, bh, idle_ok);
            checks++;
            if (lat !== RW) begin
                failures++;
                $display("FAIL latency num=%0d got=%0d exp=%0d", vals[i], lat, RW);
            end
            checks++;
            if (r !== exp_r[i]) begin
                failures++;
                $display("FAIL root num=%0d got=%0d exp=%0d", vals[i], r, exp_r[i]);
            end
`ifdef CUBE_ROOT_REM_EN
            checks++;
            if (rm !== exp_m[i]) begin
                failures++;
                $display("FAIL rem num=%0d got=%0d exp=%0d", vals[i], rm, exp_m[i]);
            end
`endif
            checks++;
            if (br !== 0 || bh !== 0 || idle_ok !== 1'b1) begin
                failures++;
                $display("FAIL protocol num=%0d got ready_err=%0d hold_err=%0d idle=%b exp 0 0 1",
                         vals[i], br, bh, idle_ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0]    r;
        logic [WIDTH-1:0] rm;
        int lat, br, bh;
        logic idle_ok;
        for (int n = 0; n <= 1625; n++) begin
            run_op(WIDTH'(n * n * n), 0, r, rm, lat, br, bh, idle_ok);
            checks++;
            if (r !== RW'(n) || rm !== '0 || lat !== RW) begin
                failures++;
                $display("FAIL round_trip n=%0d got root=%0d rem=%0d lat=%0d exp %0d 0 %0d",
                         n, r, rm, lat, n, RW);
            end
            checks++;
            if (br !== 0 || bh !== 0 || idle_ok !== 1'b1) begin
                failures++;
                $display("FAIL round_trip_proto n=%0d got ready_err=%0d hold_err=%0d idle=%b",
                         n, br, bh, idle_ok);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0]    r;
        logic [WIDTH-1:0] rm;
        logic [WIDTH-1:0] n;
        int lat, br, bh;
        logic idle_ok;
        n = $urandom;
        run_op(n, 5, r, rm, lat, br, bh, idle_ok);
        checks++;
        if (r !== RW'(ref_root(longint'(n)))) begin
            failures++;
            $display("FAIL backpressure_root num=%0d got=%0d exp=%0d", n, r, ref_root(longint'(n)));
        end
        checks++;
        if (br !== 0 || bh !== 0) begin
            failures++;
            $display("FAIL backpressure_hold got ready_err=%0d hold_err=%0d exp 0 0", br, bh);
        end
        checks++;
        if (idle_ok !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release got idle=%b exp 1", idle_ok);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [RW-1:0]    r;
        logic [WIDTH-1:0] rm;
        int lat, br, bh, stray;
        logic idle_ok;
        in_valid = 1'b1;
        num      = 32'd1000;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || root !== '0) begin
            failures++;
            $display("FAIL reset_mid_calc got out_valid=%b in_ready=%b root=%0d exp 0 1 0",
                     out_valid, in_ready, root);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        last_root = '0;
        last_rem  = '0;
        stray     = 0;
        repeat (15) begin
            @(negedge clock);
            if (out_valid) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL reset_abandon got valid_cycles=%0d exp=0", stray);
        end
        run_op(32'd1000, 0, r, rm, lat, br, bh, idle_ok);
        checks++;
        if (r !== 11'd10 || rm !== '0 || lat !== RW) begin
            failures++;
            $display("FAIL after_reset got root=%0d rem=%0d lat=%0d exp 10 0 %0d", r, rm, lat, RW);
        end
    endtask

    task automatic test_random();
        logic [RW-1:0]    r;
        logic [WIDTH-1:0] rm;
        logic [WIDTH-1:0] n;
        longint unsigned  er, k;
        int lat, br, bh;
        logic idle_ok;
        for (int i = 0; i < 150; i++) begin
            case (i % 3)
                0: n = $urandom;
                1: begin
                    k = longint'($urandom_range(1, 1625));
                    n = WIDTH'(k * k * k - 1);
                end
                default: n = WIDTH'($urandom_range(0, 4095));
            endcase
            run_op(n, int'($urandom_range(0, 2)), r, rm, lat, br, bh, idle_ok);
            er = ref_root(longint'(n));
            checks++;
            if (r !== RW'(er)) begin
                failures++;
                $display("FAIL random_root num=%0d got=%0d exp=%0d", n, r, er);
            end
`ifdef CUBE_ROOT_REM_EN
            checks++;
            if (rm !== WIDTH'(longint'(n) - er * er * er)) begin
                failures++;
                $display("FAIL random_rem num=%0d got=%0d exp=%0d", n, rm,
                         longint'(n) - er * er * er);
            end
`endif
            checks++;
            if (lat !== RW || br !== 0 || bh !== 0 || idle_ok !== 1'b1) begin
                failures++;
                $display("FAIL random_proto num=%0d got lat=%0d ready_err=%0d hold_err=%0d idle=%b",
                         n, lat, br, bh, idle_ok);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
